// File: rtl/cnn_window_gen.sv
// Streaming sliding-window generator for the CNN core input.
// Raster-order pixels in, CI x KY x KX windows out (stride 1, valid conv).
// Per-channel line buffers + window shift register; shared row/col control.

// Per-channel storage: KY-1 line buffers and the KY x KX window.
module cnn_wg_chan #(
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IMG_W  = 8,
  parameter int CW     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_acc,
  input  logic [CW-1:0]               i_col,
  input  logic [I_F_BW-1:0]           i_pix,
  output logic [KY*KX*I_F_BW-1:0]     o_win_next
);
  // r_lb[k][x] holds the pixel from row (row - (KY-1) + k) at column x
  logic [KY-2:0][IMG_W-1:0][I_F_BW-1:0] r_lb;
  logic [KY-1:0][KX-1:0][I_F_BW-1:0]    r_win;
  logic [KY-1:0][KX-1:0][I_F_BW-1:0]    w_win;
  logic [KY-1:0][I_F_BW-1:0]            w_colv;

  // New column (top = oldest row) and the window after shifting it in
  always_comb begin
    w_colv = '0;
    w_win  = '0;
    for (int ky = 0; ky < KY-1; ky++) w_colv[ky] = r_lb[ky][i_col];
    w_colv[KY-1] = i_pix;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX-1; kx++) w_win[ky][kx] = r_win[ky][kx+1];
      w_win[ky][KX-1] = w_colv[ky];
    end
  end

  // Shift window left; each line buffer takes the row below it (read-before-write)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lb  <= '0;
      r_win <= '0;
    end else if (i_acc) begin
      r_win <= w_win;
      for (int ky = 0; ky < KY-1; ky++) r_lb[ky][i_col] <= w_colv[ky+1];
    end
  end

  assign o_win_next = w_win;
endmodule

module cnn_window_gen #(
  parameter int CI     = 3,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic                          o_frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = KY*KX*I_F_BW;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_valid;
  logic                  r_done;
  logic [CI-1:0][WW-1:0] r_fmap;
  logic [CI-1:0][WW-1:0] w_win_next;
  logic                  w_acc;
  logic                  w_win_ok;
  logic                  w_last;

  // Soft reset drops a coincident pixel, so it never reaches the buffers
  assign w_acc    = i_in_valid && !i_soft_reset;
  assign w_win_ok = (r_row >= RW'(KY-1)) && (r_col >= CW'(KX-1));
  assign w_last   = (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));

  genvar g;
  generate
    for (g = 0; g < CI; g++) begin : g_chan
      cnn_wg_chan #(
        .KX(KX), .KY(KY), .I_F_BW(I_F_BW), .IMG_W(IMG_W), .CW(CW)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_acc      (w_acc),
        .i_col      (r_col),
        .i_pix      (i_in_pixel[g*I_F_BW +: I_F_BW]),
        .o_win_next (w_win_next[g])
      );
    end
  endgenerate

  // Raster counters, output strobes and the registered window
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_fmap  <= '0;
    end else if (i_soft_reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_acc && w_win_ok;
      r_done  <= w_acc && w_last;
      if (w_acc && w_win_ok) r_fmap <= w_win_next;
      if (w_acc) begin
        if (r_col == CW'(IMG_W-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_H-1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign o_ot_valid   = r_valid;
  assign o_frame_done = r_done;
  assign o_ot_fmap    = r_fmap;
endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Streaming sliding-window generator that feeds the CNN core input: accepts one CI-channel pixel per valid cycle, raster order, IMG_W x IMG_H frame.
- Emits a CI x KY x KX window in the CNN core's packed input-fmap format, stride 1, no padding ("valid" convolution).
- Built from KY-1 line buffers plus a KY x KX shift-register window, per channel. No backpressure: the downstream core always accepts.

Parameters:
- CI, 3, number of input channels
- KX, 3, kernel width
- KY, 3, kernel height
- I_F_BW, 8, bit width of one input-feature element
- IMG_W, 8, frame width in pixels (>= KX)
- IMG_H, 8, frame height in pixels (>= KY)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_soft_reset  input  1  synchronous frame abort, active-high
- i_in_valid  input  1  pixel strobe
- i_in_pixel  input  CI*I_F_BW  one pixel; channel c at bits [c*I_F_BW +: I_F_BW]
- o_ot_valid  output  1  window valid, one-cycle pulse per window
- o_ot_fmap  output  CI*KX*KY*I_F_BW  packed window
- o_frame_done  output  1  pulses together with the last window of a frame

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset: row and column counters = 0, o_ot_valid = 0, o_frame_done = 0, o_ot_fmap = 0. Line-buffer and window contents are cleared to 0.
- i_soft_reset has the same effect as reset on the counters, o_ot_valid and o_frame_done.
  - It does not clear the line buffers or o_ot_fmap.
  - If it coincides with i_in_valid, soft reset wins and the pixel is dropped.
- Pixel acceptance: every cycle with i_in_valid = 1 (and no reset) accepts one pixel at the current (row, col).
  - col increments and wraps at IMG_W-1 to 0, and row then increments.
  - row wraps at IMG_H-1 to 0, so back-to-back frames need no gap.
- Idle cycles (i_in_valid = 0): all state holds; o_ot_valid = 0 and o_frame_done = 0 the next cycle.
- Window condition: the accepted pixel satisfies row >= KY-1 and col >= KX-1.
- Latency: exactly 1 cycle. The window is registered on the accept edge, so o_ot_valid is high the cycle after the accept.
- Window content: pixel(r, x) for r = row-KY+1..row and x = col-KX+1..col, including the pixel just accepted.
- Packing: element (ci, ky, kx) sits at bit offset (((ci*KY + ky)*KX) + kx)*I_F_BW.
  - ky = 0 is the oldest (top) row; kx = 0 is the leftmost (oldest) column.
- The window shift register is not flushed at row wrap. Windows are only flagged valid once KX columns of the new row have entered, so stale columns never appear in a valid window.
- o_ot_fmap holds its last value while o_ot_valid = 0.
- Windows per frame: (IMG_W-KX+1)*(IMG_H-KY+1). Defaults give 6*6 = 36.
- o_frame_done is high exactly with the window produced by the accept at (IMG_H-1, IMG_W-1).
- Line buffers: KY-1 rows of IMG_W x CI*I_F_BW each, written at the column index. Read-before-write in the same cycle returns the previous row's value.
- Pure data movement: no arithmetic, so no width growth.

Test Plan:
- Stimulus convention: channel c of pixel (r, x) = r*8 + x + 64*c.
- Single frame, continuous valid, defaults:
  - First o_ot_valid comes 1 cycle after accepting pixel index 18 (row 2, col 2).
  - Element (0,0,0) = 0, (0,2,2) = 18, (1,1,1) = 73, (2,0,2) = 130.
  - Exactly 36 valid pulses; o_frame_done only on the 36th, whose element (0,2,2) = 63.
- Random i_in_valid gaps (about 50% duty): identical 36 windows in identical order.
  - Each o_ot_valid comes exactly one cycle after its triggering accept; no pulse follows a non-accept cycle.
- Row-wrap check: the window after accepting (3, 2) has top-left (0,0,0) = 8 and (0,0,2) = 10.
  - No valid pulse follows accepts at (3, 0) or (3, 1).
- Two back-to-back frames, no gap: 72 windows total, two o_frame_done pulses.
  - Frame 2's first window equals frame 1's first window.
- i_soft_reset asserted with i_in_valid at pixel index 30, then a fresh full frame:
  - No output on the aborted pixel.
  - The fresh frame's first window appears after its 19th pixel with element (0,0,0) = 0; exactly 36 windows follow.
- reset mid-frame, then a full frame: outputs read 0 the cycle after reset, followed by the same 36-window sequence as the first test.
